timer_countdown: RTL and testbench

- Downstream stage of the APB write/store front end.
- Takes the stored 8-bit value and a load strobe from the register stage, divides PCLK by a programmable prescaler, and counts down.
- Pulses trig on expiry, keeps a sticky interrupt flag, and exposes the live count for the read path.
- Modes: one-shot or auto-reload.

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_countdown_if.sv | 31 +++
 rtl/timer_prescaler.sv | 36 +++
 rtl/timer_countdown.sv | 119 +++++++++++
 tb/tb_timer_countdown.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the prescaled countdown timer: state encoding,
// default widths and reload-mode constants.
package timer_pkg;

  localparam int TIMER_WIDTH   = 8;
  localparam int TIMER_PRESC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADED  = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_countdown_if.sv
// Control/status bundle between the register stage (master) and the
// countdown timer (slave).
interface timer_countdown_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);

  logic               load_valid;
  logic [WIDTH-1:0]   load_data;
  logic               enable;
  logic               mode;
  logic [PRESC_W-1:0] presc_div;
  logic               irq_clr;

  logic               tick;
  logic [WIDTH-1:0]   count;
  logic               trig;
  logic               irq_flag;
  logic               busy;

  modport master (
    output load_valid, load_data, enable, mode, presc_div, irq_clr,
    input  tick, count, trig, irq_flag, busy
  );

  modport slave (
    input  load_valid, load_data, enable, mode, presc_div, irq_clr,
    output tick, count, trig, irq_flag, busy
  );

endinterface

// File: rtl/timer_prescaler.sv
// PCLK divider for the countdown timer. Produces a combinational tick
// event (used by the counter in the same cycle) and its registered copy.
module timer_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               tick_event,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  // Compare is equality only: if presc_div drops below the running count,
  // the count wraps through the top of its range before matching again.
  assign tick_event = run && (presc_cnt == presc_div);

  // Divider count: cleared on load, frozen whenever the timer is not running.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= tick_event;
      if (clr) begin
        presc_cnt <= '0;
      end else if (run) begin
        presc_cnt <= tick_event ? '0 : presc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_countdown.sv
// Prescaled down-counter with one-shot / auto-reload modes, one-cycle
// expiry pulse and sticky interrupt flag.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | no value loaded since reset, nothing counts
//   ST_LOADED  | value loaded (or run paused), waiting for enable
//   ST_RUN     | prescaler running, count decrements on each tick
//   ST_EXPIRED | one-shot expiry reached, count held at 0 until reload
module timer_countdown
  import timer_pkg::*;
#(
  parameter int WIDTH   = TIMER_WIDTH,
  parameter int PRESC_W = TIMER_PRESC_W
) (
  input  logic            PCLK,
  input  logic            PRESET,
  timer_countdown_if.slave bus
);

  timer_state_e      state, state_nxt;
  logic [WIDTH-1:0]  count, count_nxt;
  logic [WIDTH-1:0]  reload_reg, reload_nxt;
  logic              trig, irq_flag, busy;
  logic              expire;
  logic              irq_nxt;
  logic              presc_run;
  logic              tick_event;
  logic              tick;

  // A load in the same cycle always wins, so the prescaler is gated off
  // and no tick event (hence no expiry) can be seen alongside it.
  assign presc_run = (state == ST_RUN) && bus.enable && !bus.load_valid;

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .run        (presc_run),
    .clr        (bus.load_valid),
    .presc_div  (bus.presc_div),
    .tick_event (tick_event),
    .tick       (tick)
  );

  // Next-state, counter and expiry decode.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    expire     = 1'b0;
    if (bus.load_valid) begin
      reload_nxt = bus.load_data;
      count_nxt  = bus.load_data;
      state_nxt  = ST_LOADED;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_LOADED: begin
          if (bus.enable) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.enable) begin
            state_nxt = ST_LOADED;
          end else if (tick_event) begin
            if (count > WIDTH'(1)) begin
              count_nxt = count - WIDTH'(1);
            end else begin
              expire = 1'b1;
              if (bus.mode == MODE_RELOAD) begin
                count_nxt = reload_reg;
              end else begin
                count_nxt = '0;
                state_nxt = ST_EXPIRED;
              end
            end
          end
        end
        ST_EXPIRED: begin
          count_nxt = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
    // Set beats clear when both land in the same cycle.
    irq_nxt = expire ? 1'b1 : (bus.irq_clr ? 1'b0 : irq_flag);
  end

  // State, counter and status registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      trig       <= 1'b0;
      irq_flag   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      trig       <= expire;
      irq_flag   <= irq_nxt;
      busy       <= (state_nxt == ST_RUN);
    end
  end

  assign bus.tick     = tick;
  assign bus.count    = count;
  assign bus.trig     = trig;
  assign bus.irq_flag = irq_flag;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: table-driven basic sequence, hand-written
// corner cases and randomized traffic against a behavioural model.
module tb_timer_countdown;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;
  localparam int PMOD    = 1 << PRESC_W;

  logic PCLK;
  logic PRESET;

  timer_countdown_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  timer_countdown #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Behavioural model: a loaded value, whether it is counting, how far the
  // divider has advanced, and the sticky flag.
  bit m_have, m_run, m_irq, e_tick, e_trig;
  int m_cnt, m_rel, m_pc;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_run = 0; m_irq = 0; e_tick = 0; e_trig = 0;
    m_cnt = 0; m_rel = 0; m_pc = 0;
  endtask

  task automatic model_step();
    bit ev, ex;
    if (PRESET) begin
      model_reset();
      return;
    end
    ev = m_run && bus.enable && !bus.load_valid && (m_pc == int'(bus.presc_div));
    ex = ev && (m_cnt <= 1);
    e_tick = ev;
    e_trig = ex;
    if (bus.load_valid) begin
      m_rel = int'(bus.load_data); m_cnt = m_rel; m_pc = 0;
      m_run = 0; m_have = 1;
    end else if (m_run) begin
      if (!bus.enable) begin
        m_run = 0;
      end else begin
        m_pc = ev ? 0 : (m_pc + 1) % PMOD;
        if (ev) begin
          if (!ex) m_cnt = m_cnt - 1;
          else if (bus.mode) m_cnt = m_rel;
          else begin m_cnt = 0; m_run = 0; m_have = 0; end
        end
      end
    end else if (m_have && bus.enable) begin
      m_run = 1;
    end
    if (ex) m_irq = 1;
    else if (bus.irq_clr) m_irq = 0;
  endtask

  task automatic step();
    @(posedge PCLK);
    model_step();
    cyc++;
    #1;
    chk("tick",     int'(bus.tick),     int'(e_tick));
    chk("trig",     int'(bus.trig),     int'(e_trig));
    chk("count",    int'(bus.count),    m_cnt);
    chk("irq_flag", int'(bus.irq_flag), int'(m_irq));
    chk("busy",     int'(bus.busy),     int'(m_run));
  endtask

  typedef struct {
    int lv, ld, en, md, pd, clr;
    int x_count, x_tick, x_trig, x_irq, x_busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, t_last, k_last, found;
    vecs[0] = '{1, 5, 1, 0, 0, 0, 5, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 1};
    vecs[2] = '{0, 0, 1, 0, 0, 0, 4, 1, 0, 0, 1};
    vecs[3] = '{0, 0, 1, 0, 0, 0, 3, 1, 0, 0, 1};
    vecs[4] = '{0, 0, 1, 0, 0, 0, 2, 1, 0, 0, 1};
    vecs[5] = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1};
    vecs[6] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0};
    vecs[7] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

    bus.load_valid = 0; bus.load_data = '0; bus.enable = 0;
    bus.mode = 0; bus.presc_div = '0; bus.irq_clr = 0;
    PRESET = 1;
    model_reset();
    step();
    step();
    chk("reset_count", int'(bus.count), 0);
    chk("reset_busy",  int'(bus.busy), 0);
    PRESET = 0;

    // Test 1: one-shot of 5 ticks, divide-by-1.
    for (int i = 0; i < 8; i++) begin
      bus.load_valid = 1'(vecs[i].lv); bus.load_data = 8'(vecs[i].ld);
      bus.enable = 1'(vecs[i].en); bus.mode = 1'(vecs[i].md);
      bus.presc_div = 4'(vecs[i].pd); bus.irq_clr = 1'(vecs[i].clr);
      step();
      chk($sformatf("t1_count[%0d]", i), int'(bus.count), vecs[i].x_count);
      chk($sformatf("t1_tick[%0d]", i),  int'(bus.tick),  vecs[i].x_tick);
      chk($sformatf("t1_trig[%0d]", i),  int'(bus.trig),  vecs[i].x_trig);
      chk($sformatf("t1_irq[%0d]", i),   int'(bus.irq_flag), vecs[i].x_irq);
      chk($sformatf("t1_busy[%0d]", i),  int'(bus.busy),  vecs[i].x_busy);
    end

    // Test 2: auto-reload of 3 at divide-by-3.
    bus.load_valid = 1; bus.load_data = 8'd3; bus.presc_div = 4'd2;
    bus.mode = 1; bus.enable = 1;
    step();
    bus.load_valid = 0;
    t_last = -1; k_last = -1; n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.tick) begin
        if (k_last >= 0) chk("t2_tick_period", cyc - k_last, 3);
        k_last = cyc;
      end
      if (bus.trig) begin
        if (t_last >= 0) chk("t2_trig_period", cyc - t_last, 9);
        chk("t2_reload", int'(bus.count), 3);
        t_last = cyc;
        n++;
      end
      chk("t2_irq_sticky", int'(bus.irq_flag), 1);
    end
    chk("t2_trig_count", int'(n >= 4), 1);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (bus.trig) found = 1;
    end
    chk("t2_trig_seen", found, 1);
    bus.irq_clr = 1;
    step();
    bus.irq_clr = 0;
    chk("t2_irq_clr", int'(bus.irq_flag), 0);

    // Test 3: pause at count 6 then resume.
    bus.load_valid = 1; bus.load_data = 8'd10; bus.presc_div = 4'd0; bus.mode = 0;
    step();
    bus.load_valid = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.count == 8'd6) found = 1;
    end
    chk("t3_reach6", found, 1);
    bus.enable = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_count", int'(bus.count), 6);
      chk("t3_hold_busy",  int'(bus.busy), 0);
    end
    bus.enable = 1;
    n = 0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (bus.tick) n++;
      if (bus.trig) found = 1;
    end
    chk("t3_trig_seen", found, 1);
    chk("t3_ticks_to_trig", n, 6);

    // Test 4a: load of 0 expires on the first tick.
    bus.load_valid = 1; bus.load_data = 8'd0;
    step();
    bus.load_valid = 0;
    step();
    step();
    chk("t4a_trig",  int'(bus.trig), 1);
    chk("t4a_count", int'(bus.count), 0);
    bus.irq_clr = 1;
    step();
    bus.irq_clr = 0;

    // Test 4b: load coincident with the expiring tick.
    bus.load_valid = 1; bus.load_data = 8'd2;
    step();
    bus.load_valid = 0;
    step();
    step();
    chk("t4b_pre_count", int'(bus.count), 1);
    bus.load_valid = 1; bus.load_data = 8'd7;
    step();
    bus.load_valid = 0;
    chk("t4b_trig",  int'(bus.trig), 0);
    chk("t4b_count", int'(bus.count), 7);
    chk("t4b_busy",  int'(bus.busy), 0);
    chk("t4b_irq",   int'(bus.irq_flag), 0);

    // Test 5: clear coincident with expiry loses to the set.
    bus.load_valid = 1; bus.load_data = 8'd1;
    step();
    bus.load_valid = 0;
    step();
    bus.irq_clr = 1;
    step();
    chk("t5_trig", int'(bus.trig), 1);
    chk("t5_irq_set_wins", int'(bus.irq_flag), 1);
    bus.irq_clr = 0;
    step();
    bus.irq_clr = 1;
    step();
    bus.irq_clr = 0;
    chk("t5_irq_cleared", int'(bus.irq_flag), 0);

    // Randomized traffic against the model.
    bus.load_valid = 1; bus.load_data = 8'd4;
    step();
    for (int i = 0; i < 600; i++) begin
      bus.load_valid = ($urandom_range(0, 15) == 0);
      bus.load_data  = 8'($urandom_range(0, 10));
      bus.enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) bus.presc_div = 4'($urandom_range(0, 5));
      bus.irq_clr    = ($urandom_range(0, 7) == 0);
      step();
    end
    bus.load_valid = 0; bus.irq_clr = 0;

    // Test 6: asynchronous reset mid-run at count 4.
    bus.load_valid = 1; bus.load_data = 8'd8; bus.presc_div = 4'd1;
    bus.mode = 0; bus.enable = 1;
    step();
    bus.load_valid = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.count == 8'd4) found = 1;
    end
    chk("t6_reach4", found, 1);
    #2;
    PRESET = 1;
    #1;
    chk("t6_async_count", int'(bus.count), 0);
    chk("t6_async_busy",  int'(bus.busy), 0);
    chk("t6_async_tick",  int'(bus.tick), 0);
    chk("t6_async_trig",  int'(bus.trig), 0);
    chk("t6_async_irq",   int'(bus.irq_flag), 0);
    model_reset();
    step();
    PRESET = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_idle_count", int'(bus.count), 0);
      chk("t6_idle_busy",  int'(bus.busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
